div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clock, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on clock rising edge.
REQ-003 SHALL have port div_start, input, 1 bit: start request, sampled each rising edge.
REQ-004 SHALL have port A, input, 32 bits: dividend, signed two's complement, sampled only on the edge that accepts div_start.
REQ-005 SHALL have port B, input, 32 bits: divisor, signed two's complement, sampled only on the edge that accepts div_start.
REQ-006 SHALL have port HI, output reg, 32 bits: remainder of the last completed division.
REQ-007 SHALL have port LO, output reg, 32 bits: quotient of the last completed division.
REQ-008 SHALL have port div_end, output reg, 1 bit: completion pulse.
REQ-009 SHALL have port div_zero, output reg, 1 bit: divide-by-zero flag, valid with div_end.

Function
REQ-010 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-011 SHALL, in any state, when div_start=1 (and reset=0), capture A/B, abort any division in progress, and enter CALC; a new start always wins over the current operation.
REQ-012 SHALL, on capture, store |A| and |B| as 32-bit unsigned magnitudes and record sign_q = A[31]^B[31] and sign_r = A[31].
REQ-013 SHALL, on capture with B=0, skip CALC and enter DONE directly, setting div_zero=1, leaving HI/LO unchanged.
REQ-014 SHALL, in CALC, perform one restoring-division step per cycle: shift {rem,quo} left by 1, trial-subtract the divisor magnitude from the 33-bit remainder, keep the result and set quotient LSB=1 if non-negative, otherwise restore and set LSB=0.
REQ-015 SHALL use a 6-bit step counter, loaded with 32 on capture and decremented per CALC cycle, leaving CALC for FIX after exactly 32 steps.
REQ-016 SHALL, in FIX, negate the quotient if sign_q=1 and the remainder if sign_r=1, write quotient to LO and remainder to HI, and enter DONE.
REQ-017 SHALL assert div_end=1 for exactly one cycle in DONE, then return to IDLE; div_end=0 in all other states.
REQ-018 SHALL, for a non-zero divisor, make div_end first visible after the 34th rising edge following the capturing edge (32 CALC + 1 FIX + DONE entry).
REQ-019 SHALL, for divide-by-zero, make div_end and div_zero visible after the first rising edge following the capturing edge.
REQ-020 SHALL clear div_zero on the next capture; div_zero=0 for every non-zero-divisor result.
REQ-021 SHALL produce MIPS DIV semantics: quotient truncated toward zero, remainder sign equal to dividend sign, A = LO*B + HI for all B != 0.
REQ-022 SHALL handle A=0x80000000 (magnitude 2^31 representable unsigned) and B=0xFFFFFFFF by wrapping to LO=0x80000000, HI=0, div_zero=0.
REQ-023 SHALL hold HI/LO stable from FIX write until the next FIX write or reset; outputs SHALL NOT show intermediate values.
REQ-024 SHALL ignore A/B changes while not capturing.

Reset
REQ-025 SHALL, on reset=1, force state IDLE, counter 0, all internal registers 0, HI=0, LO=0, div_end=0, div_zero=0.
REQ-026 SHALL give reset priority over div_start in the same cycle.
REQ-027 SHALL, on reset mid-CALC/FIX, discard the operation with no div_end pulse and no HI/LO update.

Verification
REQ-028 A=7, B=2, start -> after 34 edges div_end pulse, LO=0x00000003, HI=0x00000001, div_zero=0.
REQ-029 A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; A=7, B=-2 -> LO=0xFFFFFFFD, HI=0x00000001.
REQ-030 A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000, div_zero=0.
REQ-031 Prior result LO=3/HI=1, then A=5, B=0 -> div_end and div_zero one edge after capture, LO=3, HI=1 unchanged.
REQ-032 Start A=100, B=7, reset at step 10 -> no div_end, HI=LO=0; then restart A=100, B=7 -> LO=14, HI=2.
REQ-033 Start A=100, B=7, re-start at step 20 with A=9, B=3 -> single div_end 34 edges after second start, LO=3, HI=0.

Source files
------------

// File: rtl/div_unit_if.sv
// Handshake and data bundle for the signed 32-bit divider.
// The divider takes the slave side and the requester takes the master side.
interface div_unit_if;
  logic        div_start;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        div_end;
  logic        div_zero;

  modport master (output div_start, A, B, input HI, LO, div_end, div_zero);
  modport slave  (input div_start, A, B, output HI, LO, div_end, div_zero);
endinterface

// File: rtl/div_unit.sv
// Multi-cycle signed 32-bit divider with MIPS DIV semantics (LO = quotient, HI = remainder).
// Restoring division on magnitudes, one bit per cycle, with a sign fix-up afterwards.
module div_unit (
  input  logic       clock,
  input  logic       reset,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        sign_quo_q, sign_quo_d;
  logic        sign_rem_q, sign_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        end_q, end_d;
  logic        zero_q, zero_d;

  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_sh, trial;

  // Negation of 0x80000000 wraps to itself, which reads correctly as 2^31 unsigned.
  assign a_mag  = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
  assign b_mag  = bus.B[31] ? (~bus.B + 32'd1) : bus.B;
  assign rem_sh = {rem_q, quo_q[31]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    zero_d     = zero_q;
    end_d      = 1'b0;

    if (bus.div_start) begin
      // A new start aborts whatever is running, including a pending completion pulse.
      sign_quo_d = bus.A[31] ^ bus.B[31];
      sign_rem_d = bus.A[31];
      rem_d      = 32'd0;
      quo_d      = a_mag;
      dvs_d      = b_mag;
      cnt_d      = 6'd32;
      zero_d     = (bus.B == 32'd0);
      state_d    = (bus.B == 32'd0) ? DONE : CALC;
    end else begin
      case (state_q)
        CALC: begin
          if (!trial[32]) begin
            rem_d = trial[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = rem_sh[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = FIX;
        end
        FIX: begin
          lo_d    = sign_quo_q ? (~quo_q + 32'd1) : quo_q;
          hi_d    = sign_rem_q ? (~rem_q + 32'd1) : rem_q;
          state_d = DONE;
        end
        DONE: begin
          end_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      dvs_q      <= 32'd0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      end_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      end_q      <= end_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;
  assign bus.div_end  = end_q;
  assign bus.div_zero = zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: signed cases, wrap case, divide-by-zero, reset abort, restart.
module tb_div_unit;
  logic clock;
  logic reset;
  int   total;
  int   bad;
  int   pulses;
  int   p0;

  div_unit_if bus ();

  div_unit u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) if (bus.div_end === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Capture happens on the posedge inside this task; returns on the following negedge
  // with junk on A/B so any late sampling would be visible.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    bus.div_start = 1'b1;
    bus.A = a;
    bus.B = b;
    @(negedge clock);
    bus.div_start = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lo, input logic [31:0] hi);
    start(a, b);
    step(33);
    chk({tag, "_end_early"}, {31'd0, bus.div_end}, 32'd0);
    step(1);
    chk({tag, "_end"}, {31'd0, bus.div_end}, 32'd1);
    chk({tag, "_lo"}, bus.LO, lo);
    chk({tag, "_hi"}, bus.HI, hi);
    chk({tag, "_zero"}, {31'd0, bus.div_zero}, 32'd0);
    step(1);
    chk({tag, "_end_drop"}, {31'd0, bus.div_end}, 32'd0);
  endtask

  initial begin
    total = 0; bad = 0; pulses = 0;
    // reset asserted together with a start request: reset must win
    reset = 1'b1;
    bus.div_start = 1'b1;
    bus.A = 32'd7;
    bus.B = 32'd2;
    step(3);
    bus.div_start = 1'b0;
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    chk("rst_end", {31'd0, bus.div_end}, 32'd0);
    chk("rst_zero", {31'd0, bus.div_zero}, 32'd0);
    reset = 1'b0;
    step(40);
    chk("rst_no_pulse", pulses, 0);

    run("pos", 32'd7, 32'd2, 32'h0000_0003, 32'h0000_0001);
    run("negA", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run("negB", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
    run("wrap", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
    run("big", 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF);

    // divide by zero keeps the previous result
    run("prior", 32'd7, 32'd2, 32'h0000_0003, 32'h0000_0001);
    start(32'd5, 32'd0);
    step(1);
    chk("dz_end", {31'd0, bus.div_end}, 32'd1);
    chk("dz_zero", {31'd0, bus.div_zero}, 32'd1);
    chk("dz_lo", bus.LO, 32'd3);
    chk("dz_hi", bus.HI, 32'd1);
    step(1);
    chk("dz_end_drop", {31'd0, bus.div_end}, 32'd0);
    run("negboth", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);

    // reset in the middle of CALC discards the operation
    start(32'd100, 32'd7);
    step(9);
    p0 = pulses;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(40);
    chk("abort_no_pulse", pulses, p0);
    chk("abort_lo", bus.LO, 32'd0);
    chk("abort_hi", bus.HI, 32'd0);
    run("rerun", 32'd100, 32'd7, 32'd14, 32'd2);

    // restart mid-CALC: only the second operation completes
    start(32'd100, 32'd7);
    step(18);
    p0 = pulses;
    run("restart", 32'd9, 32'd3, 32'd3, 32'd0);
    step(5);
    chk("restart_one_pulse", pulses, p0 + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
